// File: rtl/uart_rx_pkg.sv
// Package: uart_rx_pkg
// Shared types and constants for the UART receive FIFO.
//   rx_entry_t        one FIFO entry {fErr, pErr, dat[7:0]}
//   RX_ENTRY_W        packed width of rx_entry_t (10)
//   TIMEOUT_TICKS_DEF default idle length in brTick8x ticks
//                     (4 characters x 10 bits x 8 ticks per bit)
package uart_rx_pkg;

    localparam int RX_ENTRY_W        = 10;
    localparam int TIMEOUT_TICKS_DEF = 320;

    typedef struct packed {
        logic       fErr;
        logic       pErr;
        logic [7:0] dat;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Module: rx_fifo_ram
// DEPTH x rx_entry_t storage for the receive FIFO.
//   clk      system clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  entry to store
//   raddr_i  asynchronous read index
//   rdata_o  entry at raddr_i (combinational)
// Storage is not reset; the control logic never exposes an unwritten slot.
module rx_fifo_ram
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  rx_entry_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output rx_entry_t     rdata_o
);

    rx_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Module: uart_rx_fifo
// Receive buffer behind the UART receive core. Each byte strobed in with
// moveDatEn is stored with its parity/framing error bits; the head entry is
// presented show-ahead on rdDat/rdPErr/rdFErr and popped with rdEn.
// Sticky status: overrun (byte dropped while full), pErrSt, fErrSt.
// irq = level (rxThresh != 0 && count >= rxThresh) | overrun | timeout.
// Optional feature macro: UART_RX_TIMEOUT_EN enables the character timeout
// (idle counter on brTick8x while not empty). Without it timeout is tied 0
// and brTick8x is unused.
// Ports:
//   clk, arst (async, active-high)
//   moveDatEn, dat[7:0], setPErr, setFErr   write side from the receiver
//   brTick8x                                8x baud tick (timeout only)
//   rdEn, clrErr, rxThresh[AW:0]            bus side controls
//   rdDat, rdPErr, rdFErr                   head entry (zero when empty)
//   empty, full, count[AW:0]                fill status
//   overrun, pErrSt, fErrSt, timeout, irq   status / interrupt
// All outputs are registered except irq.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter  int DEPTH         = 8,
    parameter  int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        moveDatEn,
    input  logic [7:0]  dat,
    input  logic        setPErr,
    input  logic        setFErr,
    input  logic        brTick8x,
    input  logic        rdEn,
    input  logic        clrErr,
    input  logic [AW:0] rxThresh,
    output logic [7:0]  rdDat,
    output logic        rdPErr,
    output logic        rdFErr,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count,
    output logic        overrun,
    output logic        pErrSt,
    output logic        fErrSt,
    output logic        timeout,
    output logic        irq
);

    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic          overrun_q, overrun_d, pErr_q, pErr_d, fErr_q, fErr_d;
    rx_entry_t     head_q, head_d, wr_entry, ram_rdata;
    logic          push, pop, drop;

    // Read port looks at the next-cycle head so the head can be registered.
    rx_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wrPtr_q),
        .wdata_i (wr_entry),
        .raddr_i (rdPtr_d),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_entry = '{fErr: setFErr, pErr: setPErr, dat: dat};
        pop      = rdEn && !empty_q;
        // When full, a simultaneous pop frees the slot being written.
        push     = moveDatEn && (!full_q || rdEn);
        drop     = moveDatEn && full_q && !rdEn;

        wrPtr_d  = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d  = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        empty_d  = (count_d == '0);
        full_d   = (count_d == (AW+1)'(DEPTH));

        // The only way the new head is the slot being written this cycle is
        // a push that leaves exactly one entry; the RAM has not stored it yet.
        if (empty_d)                          head_d = '0;
        else if (push && rdPtr_d == wrPtr_q)  head_d = wr_entry;
        else                                  head_d = ram_rdata;

        // Set events win over clrErr.
        overrun_d = drop | (overrun_q & ~clrErr);
        pErr_d    = (push & setPErr) | (pErr_q & ~clrErr);
        fErr_d    = (push & setFErr) | (fErr_q & ~clrErr);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            head_q    <= '0;
            overrun_q <= 1'b0;
            pErr_q    <= 1'b0;
            fErr_q    <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            head_q    <= head_d;
            overrun_q <= overrun_d;
            pErr_q    <= pErr_d;
            fErr_q    <= fErr_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int            TW   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

    logic [TW-1:0] idle_q, idle_d;
    logic          to_q, to_d, to_set;

    always_comb begin
        idle_d = idle_q;
        to_set = 1'b0;
        if (empty_q || push || pop) begin
            idle_d = '0;
        end else if (brTick8x && idle_q != TMAX) begin
            idle_d = idle_q + TW'(1);
            // Fire only on the tick that reaches the limit; while the counter
            // holds, clrErr can clear the flag without it re-asserting.
            to_set = (idle_d == TMAX);
        end
        to_d = to_set | (to_q & ~(push | pop | clrErr));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else begin
            idle_q <= idle_d;
            to_q   <= to_d;
        end
    end

    assign timeout = to_q;
`else
    logic unused_brtick;
    assign unused_brtick = brTick8x;
    assign timeout       = 1'b0;
`endif

    assign rdDat   = head_q.dat;
    assign rdPErr  = head_q.pErr;
    assign rdFErr  = head_q.fErr;
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;
    assign overrun = overrun_q;
    assign pErrSt  = pErr_q;
    assign fErrSt  = fErr_q;
    assign irq     = ((rxThresh != '0) && (count_q >= rxThresh)) | overrun_q | timeout;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    import uart_rx_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TT    = 320;

    logic        clk = 1'b0, arst = 1'b1;
    logic        moveDatEn = 0, setPErr = 0, setFErr = 0, brTick8x = 0, rdEn = 0, clrErr = 0;
    logic [7:0]  dat = '0;
    logic [AW:0] rxThresh = '0;
    logic [7:0]  rdDat;
    logic        rdPErr, rdFErr, empty, full, overrun, pErrSt, fErrSt, timeout, irq;
    logic [AW:0] count;

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TT)) dut (
        .clk(clk), .arst(arst), .moveDatEn(moveDatEn), .dat(dat),
        .setPErr(setPErr), .setFErr(setFErr), .brTick8x(brTick8x),
        .rdEn(rdEn), .clrErr(clrErr), .rxThresh(rxThresh),
        .rdDat(rdDat), .rdPErr(rdPErr), .rdFErr(rdFErr), .empty(empty),
        .full(full), .count(count), .overrun(overrun), .pErrSt(pErrSt),
        .fErrSt(fErrSt), .timeout(timeout), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Expected FIFO contents as a plain queue; status from the rules directly.
    rx_entry_t mq[$];
    bit        m_ovr, m_pe, m_fe, m_to;
    int        m_idle;
    rx_entry_t m_head, m_in;
    bit        m_pop, m_acc, m_drop, m_set;
    int        m_sz;

    always @(negedge clk) begin
        if (arst) begin
            mq.delete();
            m_ovr = 0; m_pe = 0; m_fe = 0; m_to = 0; m_idle = 0;
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_rdDat", rdDat, 0);
            chk("rst_flags", {overrun, pErrSt, fErrSt, timeout}, 0);
        end else begin
            m_sz   = mq.size();
            m_head = (m_sz > 0) ? mq[0] : '0;
            chk("rdDat", rdDat, m_head.dat);
            chk("rdPErr", rdPErr, m_head.pErr);
            chk("rdFErr", rdFErr, m_head.fErr);
            chk("count", count, m_sz);
            chk("empty", empty, m_sz == 0);
            chk("full", full, m_sz == DEPTH);
            chk("overrun", overrun, m_ovr);
            chk("pErrSt", pErrSt, m_pe);
            chk("fErrSt", fErrSt, m_fe);
            chk("timeout", timeout, m_to);
            chk("irq", irq, ((rxThresh != 0) && (m_sz >= int'(rxThresh))) || m_ovr || m_to);

            // advance model with the inputs the next posedge will sample
            m_pop  = rdEn && m_sz > 0;
            m_acc  = moveDatEn && (m_sz < DEPTH || rdEn);
            m_drop = moveDatEn && m_sz == DEPTH && !rdEn;
            m_set  = 0;
`ifdef UART_RX_TIMEOUT_EN
            if (m_sz == 0 || m_acc || m_pop) m_idle = 0;
            else if (brTick8x && m_idle < TT) begin
                m_idle++;
                if (m_idle == TT) m_set = 1;
            end
            m_to = m_set || (m_to && !(m_acc || m_pop || clrErr));
`endif
            m_in = '{fErr: setFErr, pErr: setPErr, dat: dat};
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(m_in);
            m_ovr = m_drop || (m_ovr && !clrErr);
            m_pe  = (m_acc && setPErr) || (m_pe && !clrErr);
            m_fe  = (m_acc && setFErr) || (m_fe && !clrErr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit mv, input logic [7:0] d, input bit pe, input bit fe,
                       input bit rd, input bit clr, input bit tick);
        moveDatEn = mv; dat = d; setPErr = pe; setFErr = fe;
        rdEn = rd; clrErr = clr; brTick8x = tick;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 8'h00, 0, 0, 1, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
        chk("post_rst_empty", empty, 1);

        // 1: single byte in and out
        cyc(1, 8'hA5, 0, 0, 0, 0, 0);
        chk("t1_rdDat", rdDat, 8'hA5);
        chk("t1_count", count, 1);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        chk("t1_empty", empty, 1);
        chk("t1_rdDat0", rdDat, 8'h00);

        // 2: fill, overflow drops FF
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 0, 0, 0);
        cyc(1, 8'hFF, 0, 0, 0, 0, 0);
        chk("t2_full", full, 1);
        chk("t2_overrun", overrun, 1);
        chk("t2_irq", irq, 1);
        drain();
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        chk("t2_ovr_clr", overrun, 0);

        // 3: error bits per entry and sticky
        cyc(1, 8'h3C, 1, 0, 0, 0, 0);
        cyc(1, 8'h3D, 0, 1, 0, 0, 0);
        chk("t3_rdPErr", rdPErr, 1);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        chk("t3_rdFErr", rdFErr, 1);
        chk("t3_sticky", {pErrSt, fErrSt}, 2'b11);
        cyc(0, 8'h00, 0, 0, 1, 1, 0);
        chk("t3_clr", {pErrSt, fErrSt}, 2'b00);

        // 4: full with simultaneous push/pop, pointers wrap
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) cyc(1, 8'(8'h80 + i), 0, 0, 1, 0, 0);
        chk("t4_count", count, DEPTH);
        chk("t4_ovr", overrun, 0);
        drain();

        // 5: level irq
        rxThresh = 4;
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0, 0, 0);
        chk("t5_irq0", irq, 0);
        cyc(1, 8'h13, 0, 0, 0, 0, 0);
        chk("t5_irq1", irq, 1);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        chk("t5_irq2", irq, 0);
        drain();
        rxThresh = 0;

        // 6: character timeout (flag stays 0 when compiled out)
        cyc(1, 8'h55, 0, 0, 0, 0, 0);
        for (int i = 0; i < TT - 1; i++) cyc(0, 8'h00, 0, 0, 0, 0, 1);
        chk("t6_to_early", timeout, 0);
        cyc(0, 8'h00, 0, 0, 0, 0, 1);
`ifdef UART_RX_TIMEOUT_EN
        chk("t6_to_set", timeout, 1);
        chk("t6_irq", irq, 1);
`else
        chk("t6_to_off", timeout, 0);
`endif
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        chk("t6_to_pop", timeout, 0);
        cyc(1, 8'h66, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) cyc(0, 8'h00, 0, 0, 0, 0, 1);
        arst = 1'b1;
        @(negedge clk); #1 arst = 1'b0;
        @(posedge clk); #2;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_to", timeout, 0);

        // random phases alternating fill-heavy and drain-heavy traffic
        for (int p = 0; p < 12; p++) begin
            int pm, pr;
            pm = (p % 2 == 0) ? 80 : 30;
            pr = (p % 2 == 0) ? 25 : 70;
            rxThresh = (AW+1)'($urandom_range(DEPTH));
            for (int i = 0; i < 250; i++)
                cyc($urandom_range(99) < pm, 8'($urandom), $urandom_range(9) == 0,
                    $urandom_range(9) == 0, $urandom_range(99) < pr,
                    $urandom_range(19) == 0, $urandom_range(99) < 60);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
